alarm_event_arbiter: RTL and testbench

- Sits between the raw alarm sources and the message senders (GSM SMS sender, UART status sender).
- Alarm sources: bin-full, flame, gas, over-temperature.
- Synchronises and debounces each alarm level, then latches each rising edge as a pending event.
- Hands pending events one at a time, in fixed priority, to the sender over a valid/ready handshake, with a cooldown between messages.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/alarm_debounce.sv | 55 +++++
 rtl/alarm_event_arbiter.sv | 116 +++++++++++
 tb/tb_alarm_event_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm event arbiter: channel map, FSM encoding
// and the fixed-priority picker (lowest index wins).
package alarm_pkg;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  localparam logic [CH_W-1:0] CH_FIRE  = 2'd0;
  localparam logic [CH_W-1:0] CH_GAS   = 2'd1;
  localparam logic [CH_W-1:0] CH_FULL  = 2'd2;
  localparam logic [CH_W-1:0] CH_FEVER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  function automatic logic [CH_W-1:0] first_set(input logic [N_CH-1:0] v);
    first_set = CH_FIRE;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) first_set = CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/alarm_debounce.sv
// One alarm channel: 2-flop synchroniser plus debounce counter; the stable
// level flips DEB_CYC+2 cycles after a clean raw step, rise_o pulses 1 cycle.
module alarm_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    // Any cycle of agreement leaves cnt_d at zero.
    if (sync2_q != stable_q) begin
      if (cnt_q == DEB_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/alarm_event_arbiter.sv
// Debounces alarm levels, latches rising edges and offers them one at a time by priority over
// valid/ready, then cools down. ALARM_CANCEL_EN: a debounced fall cancels a not-yet-offered event.
module alarm_event_arbiter
  import alarm_pkg::*;
#(
  parameter int DEB_CYC      = 1000000,
  parameter int COOLDOWN_CYC = 500000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] alarm_raw,
  output logic [N_CH-1:0] alarm_stable,
  output logic [N_CH-1:0] pending,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  input  logic            evt_ready
);

  localparam int CD_W = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0);

  logic [N_CH-1:0] stable_w;
  logic [N_CH-1:0] rise_w;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    alarm_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (alarm_raw[gi]),
      .stable_o (stable_w[gi]),
      .rise_o   (rise_w[gi])
    );
  end

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic            hs;

`ifdef ALARM_CANCEL_EN
  logic [N_CH-1:0] stable_prev_q;
  logic [N_CH-1:0] fall_w;

  assign fall_w = stable_prev_q & ~stable_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_prev_q <= '0;
    else        stable_prev_q <= stable_w;
  end
`endif

  assign hs = (state_q == ST_OFFER) && evt_ready;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cd_d    = cd_q;
    pend_d  = pend_q;

`ifdef ALARM_CANCEL_EN
    // The event currently on offer is committed; only waiting ones are cancelled.
    for (int i = 0; i < N_CH; i++) begin
      if (fall_w[i] && !((state_q == ST_OFFER) && (ch_q == CH_W'(i)))) pend_d[i] = 1'b0;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          ch_d    = first_set(pend_q);
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (hs) begin
          pend_d[ch_q] = 1'b0;
          cd_d         = '0;
          state_d      = (COOLDOWN_CYC == 0) ? ST_IDLE : ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cd_q == CD_LAST) begin
          cd_d    = '0;
          state_d = ST_IDLE;
        end else begin
          cd_d = cd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge on the delivery edge wins, so that event is offered again.
    pend_d = pend_d | rise_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cd_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cd_q    <= cd_d;
      pend_q  <= pend_d;
    end
  end

  assign alarm_stable = stable_w;
  assign pending      = pend_q;
  assign evt_valid    = (state_q == ST_OFFER);
  assign evt_ch       = ch_q;

endmodule

// File: tb/tb_alarm_event_arbiter.sv
// Directed bench for alarm_event_arbiter with DEB_CYC=4, COOLDOWN_CYC=10.
module tb_alarm_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] alarm_raw;
  logic [3:0] alarm_stable;
  logic [3:0] pending;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_ready;

  int checks   = 0;
  int failures = 0;

  alarm_event_arbiter #(.DEB_CYC(4), .COOLDOWN_CYC(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alarm_raw    (alarm_raw),
    .alarm_stable (alarm_stable),
    .pending      (pending),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_ready    (evt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    alarm_raw = 4'b0000;
    evt_ready = 1'b1;
    #1;
    chk("rst_stable",  alarm_stable, 4'b0000);
    chk("rst_pending", pending,      4'b0000);
    chk("rst_valid",   evt_valid,    1'b0);
    chk("rst_ch",      evt_ch,       2'd0);
    ticks(3);
    rst_n = 1'b1;
    ticks(2);

    // Glitch of 3 cycles on gas must be rejected.
    alarm_raw = 4'b0010;
    ticks(3);
    alarm_raw = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_stable", alarm_stable, 4'b0000);
      chk("glitch_valid",  evt_valid,    1'b0);
    end
    chk("glitch_pending", pending, 4'b0000);

    // Clean step on full: stable +6, pending +7, valid +8, handshake +9.
    alarm_raw = 4'b0100;
    ticks(5);
    chk("step_stable_early", alarm_stable, 4'b0000);
    tick();
    chk("step_stable", alarm_stable, 4'b0100);
    chk("step_pending_early", pending, 4'b0000);
    tick();
    chk("step_pending", pending, 4'b0100);
    chk("step_valid_early", evt_valid, 1'b0);
    tick();
    chk("step_offer", {evt_valid, evt_ch}, {1'b1, 2'd2});
    tick();
    chk("step_hs_valid",   evt_valid, 1'b0);
    chk("step_hs_pending", pending,   4'b0000);
    alarm_raw = 4'b0000;
    ticks(25);
    chk("step_fall_stable",  alarm_stable, 4'b0000);
    chk("step_fall_pending", pending,      4'b0000);

    // Gas and fever together with sender stalled: gas offered and held.
    evt_ready = 1'b0;
    alarm_raw = 4'b1010;
    ticks(8);
    chk("prio_offer",   {evt_valid, evt_ch}, {1'b1, 2'd1});
    chk("prio_pending", pending, 4'b1010);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("prio_hold", {evt_valid, evt_ch}, {1'b1, 2'd1});
    end
    evt_ready = 1'b1;
    tick();
    chk("prio_hs1_valid",   evt_valid, 1'b0);
    chk("prio_hs1_pending", pending,   4'b1000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("prio_cooldown", evt_valid, 1'b0);
    end
    tick();
    chk("prio_offer2", {evt_valid, evt_ch}, {1'b1, 2'd3});
    tick();
    chk("prio_hs2_valid",   evt_valid, 1'b0);
    chk("prio_hs2_pending", pending,   4'b0000);
    ticks(12);

    // Fire steps during cooldown after a full delivery.
    alarm_raw = 4'b1110;
    ticks(8);
    chk("acc_offer_full", {evt_valid, evt_ch}, {1'b1, 2'd2});
    tick();
    chk("acc_hs_valid", evt_valid, 1'b0);
    alarm_raw = 4'b1111;
    ticks(7);
    chk("acc_pending", pending, 4'b0001);
    chk("acc_valid",   evt_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("acc_wait", evt_valid, 1'b0);
    end
    evt_ready = 1'b0;
    tick();
    chk("acc_offer_fire", {evt_valid, evt_ch}, {1'b1, 2'd0});

    // Re-trigger fire so its new rise lands on the handshake edge.
    alarm_raw = 4'b1110;
    ticks(8);
    chk("col_stable_low", alarm_stable, 4'b1110);
    chk("col_still_offer", {evt_valid, evt_ch}, {1'b1, 2'd0});
    chk("col_pending_hold", pending, 4'b0001);
    alarm_raw = 4'b1111;
    ticks(6);
    chk("col_stable_high", alarm_stable, 4'b1111);
    evt_ready = 1'b1;
    tick();
    chk("col_hs_valid",   evt_valid, 1'b0);
    chk("col_set_wins",   pending,   4'b0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("col_cooldown", evt_valid, 1'b0);
    end
    tick();
    chk("col_redeliver", {evt_valid, evt_ch}, {1'b1, 2'd0});
    tick();
    chk("col_done_pending", pending, 4'b0000);
    ticks(12);

    // Reset while offering fever; fever still high at release.
    evt_ready = 1'b0;
    alarm_raw = 4'b0000;
    ticks(10);
    chk("rmo_idle", {evt_valid, alarm_stable}, 5'b0);
    alarm_raw = 4'b1000;
    ticks(8);
    chk("rmo_offer", {evt_valid, evt_ch}, {1'b1, 2'd3});
    rst_n = 1'b0;
    #1;
    chk("rmo_valid",   evt_valid,    1'b0);
    chk("rmo_ch",      evt_ch,       2'd0);
    chk("rmo_pending", pending,      4'b0000);
    chk("rmo_stable",  alarm_stable, 4'b0000);
    ticks(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    ticks(5);
    chk("rel_stable_early", alarm_stable, 4'b0000);
    tick();
    chk("rel_stable", alarm_stable, 4'b1000);
    tick();
    chk("rel_pending", pending, 4'b1000);
    tick();
    chk("rel_offer", {evt_valid, evt_ch}, {1'b1, 2'd3});
    tick();
    chk("rel_done", {evt_valid, pending}, 5'b0);
    ticks(12);

`ifdef ALARM_CANCEL_EN
    // Fever pends behind a stalled gas offer, then drops before being offered.
    evt_ready = 1'b0;
    alarm_raw = 4'b0000;
    ticks(10);
    alarm_raw = 4'b0010;
    ticks(8);
    chk("cxl_offer_gas", {evt_valid, evt_ch}, {1'b1, 2'd1});
    alarm_raw = 4'b1010;
    ticks(8);
    chk("cxl_pending_set", pending, 4'b1010);
    alarm_raw = 4'b0010;
    ticks(8);
    chk("cxl_pending_clr", pending, 4'b0010);
    evt_ready = 1'b1;
    tick();
    chk("cxl_hs_pending", pending, 4'b0000);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("cxl_no_event", evt_valid, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
